// File: rtl/tqvp_bg_compositor.sv
// Composites NUM_LAYERS RGB222 background layers into one VGA pixel stream, with vsync-shadowed layer config.
// Latency: 1 cycle from layer_rgb/visible/sync inputs to rgb_out/hsync_out/vsync_out; register reads same cycle.
// Backpressure: none; data_ready is tied high and the pixel path accepts a pixel every clock.
module tqvp_bg_compositor #(
  parameter int NUM_LAYERS = 3,
  parameter int SCROLL_W   = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [5:0]                     address,
  input  logic [31:0]                    data_in,
  input  logic [1:0]                     data_write_n,
  input  logic [1:0]                     data_read_n,
  output logic [31:0]                    data_out,
  output logic                           data_ready,
  input  logic [6*NUM_LAYERS-1:0]        layer_rgb,
  input  logic                           visible,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  output logic [NUM_LAYERS-1:0]          layer_en_o,
  output logic [SCROLL_W*NUM_LAYERS-1:0] scroll_x_o,
  output logic [SCROLL_W*NUM_LAYERS-1:0] scroll_y_o,
  output logic [5:0]                     rgb_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           user_interrupt
);

  // ctrl = {mode (shadowed), conf_ie, frame_ie, enable}
  logic [3:0]            ctrl;
  logic [NUM_LAYERS-1:0] sh_en, act_en;
  logic [5:0]            sh_key, sh_bd, act_key, act_bd;
  logic                  act_mode;
  logic [SCROLL_W-1:0]   sh_x [NUM_LAYERS];
  logic [SCROLL_W-1:0]   sh_y [NUM_LAYERS];
  logic [SCROLL_W-1:0]   act_x [NUM_LAYERS];
  logic [SCROLL_W-1:0]   act_y [NUM_LAYERS];
  logic                  frame_flag, conf_flag;
  logic [7:0]            frame_cnt;
  logic                  vs_q, hs_q;

  logic                  wr_en, commit, w1c;
  logic [31:0]           wmask, wval;
  logic [3:0]            ctrl_nxt;
  logic                  frame_nxt, conf_nxt, conf_set;
  logic [5:0]            pix, pix_nxt;

  assign data_ready = 1'b1;
  assign wr_en      = (data_write_n != 2'b11);
  assign commit     = vsync_in & ~vs_q;
  assign w1c        = wr_en && (address == 6'h0C);
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign layer_en_o = act_en;

  logic unused_ok;
  assign unused_ok = &{1'b0, data_read_n, wval, data_in};

  // Byte-lane mask; the merged write value keeps untouched bits from the current register view
  always_comb begin
    case (data_write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
    wval = (data_out & ~wmask) | (data_in & wmask);
  end

  // Register read mux; reads show the shadow copies, not the active ones
  always_comb begin
    data_out = '0;
    case (address)
      6'h00: data_out[3:0] = ctrl;
      6'h04: data_out[NUM_LAYERS-1:0] = sh_en;
      6'h08: begin
        data_out[13:8] = sh_bd;
        data_out[5:0]  = sh_key;
      end
      6'h0C: begin
        data_out[15:8] = frame_cnt;
        data_out[1]    = conf_flag;
        data_out[0]    = frame_flag;
      end
      default: begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (address == 6'(16 + 4 * i)) begin
            data_out[SCROLL_W-1:0]     = sh_x[i];
            data_out[SCROLL_W+15:16]   = sh_y[i];
          end
        end
      end
    endcase
  end

  // Next state of CTRL and the sticky flags; a set on vsync rise beats a same-cycle W1C
  always_comb begin
    ctrl_nxt  = (wr_en && address == 6'h00) ? wval[3:0] : ctrl;
    conf_set  = commit & ~ctrl[3] & ($countones(sh_en) > 1);
    frame_nxt = (frame_flag & ~(w1c & data_in[0])) | commit;
    conf_nxt  = (conf_flag & ~(w1c & data_in[1])) | conf_set;
  end

  // Register file, shadow-to-active commit on vsync rise, frame counter and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl           <= '0;
      sh_en          <= '0;
      act_en         <= '0;
      sh_key         <= '0;
      sh_bd          <= '0;
      act_key        <= '0;
      act_bd         <= '0;
      act_mode       <= 1'b0;
      frame_flag     <= 1'b0;
      conf_flag      <= 1'b0;
      frame_cnt      <= '0;
      user_interrupt <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
    end else begin
      ctrl       <= ctrl_nxt;
      frame_flag <= frame_nxt;
      conf_flag  <= conf_nxt;
      user_interrupt <= (frame_nxt & ctrl_nxt[1]) | (conf_nxt & ctrl_nxt[2]);
      if (wr_en && address == 6'h04) sh_en <= wval[NUM_LAYERS-1:0];
      if (wr_en && address == 6'h08) begin
        sh_key <= wval[5:0];
        sh_bd  <= wval[13:8];
      end
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (wr_en && address == 6'(16 + 4 * i)) begin
          sh_x[i] <= wval[SCROLL_W-1:0];
          sh_y[i] <= wval[SCROLL_W+15:16];
        end
      end
      // Non-blocking copy: a same-cycle shadow write lands next frame
      if (commit) begin
        frame_cnt <= frame_cnt + 8'd1;
        act_en    <= sh_en;
        act_key   <= sh_key;
        act_bd    <= sh_bd;
        act_mode  <= ctrl[3];
        for (int i = 0; i < NUM_LAYERS; i++) begin
          act_x[i] <= sh_x[i];
          act_y[i] <= sh_y[i];
        end
      end
    end
  end

  // Flatten the active scroll offsets for the background generators
  always_comb begin
    scroll_x_o = '0;
    scroll_y_o = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      scroll_x_o[i*SCROLL_W +: SCROLL_W] = act_x[i];
      scroll_y_o[i*SCROLL_W +: SCROLL_W] = act_y[i];
    end
  end

  // Pixel selection: exclusive (single layer or backdrop, black on overlap) or priority-key
  always_comb begin
    logic [5:0] excl_pix, prio_pix;
    excl_pix = act_bd;
    prio_pix = act_bd;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (act_en[i]) begin
        excl_pix = layer_rgb[6*i +: 6];
        if (layer_rgb[6*i +: 6] != act_key) prio_pix = layer_rgb[6*i +: 6];
      end
    end
    if (act_mode)                      pix = prio_pix;
    else if ($countones(act_en) > 1)   pix = 6'h00;
    else                               pix = excl_pix;
    pix_nxt = (visible && ctrl[0]) ? pix : 6'h00;
  end

  // One-stage output pipeline keeping pixel and syncs aligned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_out <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      rgb_out <= pix_nxt;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
    end
  end

endmodule

// File: tb/tb_tqvp_bg_compositor.sv
// Directed bench for tqvp_bg_compositor: stimulus pushes expectations into a scoreboard queue,
// a negedge monitor pops each entry and compares it with the matching DUT output.
// Expected values are hand-computed from the register map and compositing rules.
module tb_tqvp_bg_compositor;
  localparam int NL = 3;
  localparam int SW = 11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [5:0]     address = '0;
  logic [31:0]    data_in = '0;
  logic [1:0]     data_write_n = 2'b11;
  logic [1:0]     data_read_n = 2'b11;
  logic [31:0]    data_out;
  logic           data_ready;
  logic [6*NL-1:0] layer_rgb = '0;
  logic           visible = 1'b0;
  logic           hsync_in = 1'b0;
  logic           vsync_in = 1'b0;
  logic [NL-1:0]  layer_en_o;
  logic [SW*NL-1:0] scroll_x_o, scroll_y_o;
  logic [5:0]     rgb_out;
  logic           hsync_out, vsync_out, user_interrupt;

  tqvp_bg_compositor #(.NUM_LAYERS(NL), .SCROLL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .layer_rgb(layer_rgb), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_en_o(layer_en_o),
    .scroll_x_o(scroll_x_o), .scroll_y_o(scroll_y_o), .rgb_out(rgb_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  localparam int K_RGB = 0, K_RD = 1, K_IRQ = 2, K_SX = 3, K_SY = 4, K_EN = 5,
                 K_HS = 6, K_VS = 7, K_RDY = 8;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    logic [95:0] name;
  } item_t;

  item_t       sb[$];
  item_t       cur;
  logic [63:0] act;
  int          total = 0;
  int          bad = 0;

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      K_RGB:   return 64'(rgb_out);
      K_RD:    return 64'(data_out);
      K_IRQ:   return 64'(user_interrupt);
      K_SX:    return 64'(scroll_x_o);
      K_SY:    return 64'(scroll_y_o);
      K_EN:    return 64'(layer_en_o);
      K_HS:    return 64'(hsync_out);
      K_VS:    return 64'(vsync_out);
      default: return 64'(data_ready);
    endcase
  endfunction

  // Monitor: drain every pending expectation away from the active edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = observe(cur.kind);
      total++;
      if (act !== cur.exp) begin
        bad++;
        $display("FAIL %0s: got 0x%0h expected 0x%0h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic chk(input int kind, input logic [63:0] exp, input logic [95:0] name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input logic [95:0] name);
    address = a;
    chk(K_RD, 64'(exp), name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address      = a;
    data_in      = d;
    data_write_n = wn;
    tick(1);
    data_write_n = 2'b11;
  endtask

  task automatic vs_rise();
    vsync_in = 1'b1;
    tick(1);
    vsync_in = 1'b0;
    tick(1);
  endtask

  task automatic set_layers(input logic [5:0] l0, input logic [5:0] l1, input logic [5:0] l2);
    layer_rgb = {l2, l1, l0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    chk(K_RGB, 64'h0, "rst_rgb");
    chk(K_IRQ, 64'h0, "rst_irq");
    chk(K_EN,  64'h0, "rst_en");
    chk(K_RDY, 64'h1, "rst_rdy");
    rd(6'h0C, 32'h0, "rst_status");
    rst_n = 1'b1;
    tick(1);

    // Exclusive mode, single layer
    set_layers(6'h11, 6'h2A, 6'h33);
    visible = 1'b1;
    wr(6'h00, 32'h1, 2'b10);
    wr(6'h04, 32'h2, 2'b10);
    chk(K_EN, 64'h0, "en_shadow");
    vsync_in = 1'b1;
    tick(1);
    chk(K_VS, 64'h1, "vsync_dly");
    vsync_in = 1'b0;
    tick(1);
    chk(K_RGB, 64'h2A, "excl_one");
    chk(K_EN,  64'h2,  "en_commit");
    chk(K_IRQ, 64'h0,  "irq_masked");
    rd(6'h0C, 32'h0101, "status1");
    hsync_in = 1'b1;
    tick(1);
    chk(K_HS, 64'h1, "hsync_dly");
    hsync_in = 1'b0;
    visible  = 1'b0;
    tick(1);
    chk(K_RGB, 64'h0, "blanked");
    visible = 1'b1;

    // Exclusive conflict
    wr(6'h00, 32'h5, 2'b10);
    wr(6'h04, 32'h3, 2'b10);
    vs_rise();
    chk(K_RGB, 64'h0, "excl_two");
    rd(6'h0C, 32'h0203, "status_conf");
    chk(K_IRQ, 64'h1, "irq_conf");
    wr(6'h0C, 32'h2, 2'b00);
    chk(K_IRQ, 64'h0, "irq_w1c");
    rd(6'h0C, 32'h0201, "status_w1c");

    // Scroll shadowing and byte lanes
    wr(6'h10, 32'h0005_0010, 2'b10);
    chk(K_SX, 64'h0, "sx_shadow");
    rd(6'h10, 32'h0005_0010, "scroll_rd");
    vs_rise();
    chk(K_SX, 64'h10, "sx_commit");
    chk(K_SY, 64'h5,  "sy_commit");
    wr(6'h10, 32'hFFFF_FFAA, 2'b00);
    rd(6'h10, 32'h0005_00AA, "lane8");
    wr(6'h10, 32'h1234_7FFF, 2'b01);
    rd(6'h10, 32'h0005_07FF, "lane16");
    chk(K_SX, 64'h10, "sx_hold");
    wr(6'h3C, 32'hFFFF_FFFF, 2'b10);
    rd(6'h3C, 32'h0, "unmapped");
    rd(6'h1C, 32'h0, "no_layer3");
    rd(6'h0C, 32'h0303, "status_conf2");
    wr(6'h0C, 32'h3, 2'b10);

    // Priority mode with key
    wr(6'h00, 32'h9, 2'b10);
    wr(6'h04, 32'h7, 2'b10);
    wr(6'h08, 32'h3F00, 2'b10);
    rd(6'h08, 32'h3F00, "key_bd_rd");
    set_layers(6'h00, 6'h15, 6'h2A);
    vs_rise();
    chk(K_RGB, 64'h15, "prio_key");
    rd(6'h0C, 32'h0401, "prio_noconf");
    set_layers(6'h00, 6'h00, 6'h00);
    tick(1);
    chk(K_RGB, 64'h3F, "prio_bd");
    set_layers(6'h01, 6'h15, 6'h2A);
    wr(6'h00, 32'h8, 2'b10);
    tick(1);
    chk(K_RGB, 64'h0, "disabled");
    wr(6'h00, 32'h9, 2'b10);
    tick(1);
    chk(K_RGB, 64'h01, "prio_low");

    // Frame counter wrap
    for (int i = 0; i < 252; i++) vs_rise();
    rd(6'h0C, 32'h0001, "cnt_wrap");
    for (int i = 0; i < 4; i++) vs_rise();
    rd(6'h0C, 32'h0401, "cnt_after");

    // W1C and vsync rise together: set wins
    address      = 6'h0C;
    data_in      = 32'h1;
    data_write_n = 2'b00;
    vsync_in     = 1'b1;
    tick(1);
    data_write_n = 2'b11;
    vsync_in     = 1'b0;
    tick(1);
    rd(6'h0C, 32'h0501, "set_wins");
    wr(6'h0C, 32'h1, 2'b00);
    rd(6'h0C, 32'h0500, "frame_clr");

    // Shadow write in the commit cycle lands next frame
    address      = 6'h04;
    data_in      = 32'h1;
    data_write_n = 2'b10;
    vsync_in     = 1'b1;
    tick(1);
    data_write_n = 2'b11;
    vsync_in     = 1'b0;
    tick(1);
    chk(K_EN, 64'h7, "same_cyc_old");
    rd(6'h04, 32'h1, "same_cyc_sh");
    vs_rise();
    chk(K_EN, 64'h1, "same_cyc_new");
    wr(6'h00, 32'hB, 2'b10);
    chk(K_IRQ, 64'h1, "irq_frame");
    rd(6'h0C, 32'h0701, "status_end");
    chk(K_RGB, 64'h01, "pre_rst_rgb");

    // Mid-line reset with interrupt pending
    rst_n = 1'b0;
    tick(1);
    chk(K_RGB, 64'h0, "mrst_rgb");
    chk(K_IRQ, 64'h0, "mrst_irq");
    chk(K_EN,  64'h0, "mrst_en");
    chk(K_SX,  64'h0, "mrst_sx");
    chk(K_RDY, 64'h1, "mrst_rdy");
    rd(6'h00, 32'h0, "mrst_ctrl");
    rd(6'h04, 32'h0, "mrst_len");
    rd(6'h08, 32'h0, "mrst_key");
    rd(6'h0C, 32'h0, "mrst_stat");
    rd(6'h10, 32'h0, "mrst_scrl");

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
